level_sequencer: RTL and testbench

- Sequences the four melody levels of the tone game by driving the 2-bit level-select input of the note-output mux.
- Counts notes within the active level, inserts a silent gap between levels, and reports per-level and whole-game completion.
- Sits between the button/tempo front end and the level-select mux; it is the only writer of the mux select.

---
 rtl/level_sequencer_pkg.sv | 18 +
 rtl/level_sequencer_rise_edge.sv | 22 ++
 rtl/level_sequencer.sv | 144 ++++++++++++++
 tb/tb_level_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the level sequencer: FSM state encoding and default sizing constants.
// The LEVEL_SEQ_LOOP_EN build option is consumed by level_sequencer.sv.
package level_sequencer_pkg;

    // NOTE: all four encodings are named, so an out-of-range state can only come from upset/X; the FSM default still recovers it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int DEF_NUM_LEVELS      = 4;
    localparam int DEF_SEL_W           = 2;
    localparam int DEF_NOTES_PER_LEVEL = 16;
    localparam int DEF_GAP_TICKS       = 8;

endpackage

// File: rtl/level_sequencer_rise_edge.sv
// Rising-edge detector for an already-synchronised level input; one pulse per low-to-high transition.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: walks the melody levels, counts notes, inserts inter-level gaps, flags completion.
// Build option: define LEVEL_SEQ_LOOP_EN to wrap from the last level back to level 0 instead of finishing.
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS      = DEF_NUM_LEVELS,
    parameter int SEL_W           = DEF_SEL_W,
    parameter int NOTES_PER_LEVEL = DEF_NOTES_PER_LEVEL,
    parameter int GAP_TICKS       = DEF_GAP_TICKS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               skip,
    input  logic                               note_tick,
    output logic [SEL_W-1:0]                   sel,
    output logic                               play_en,
    output logic [$clog2(NOTES_PER_LEVEL)-1:0] note_idx,
    output logic                               level_done,
    output logic                               all_done
);

    localparam int NOTE_W = $clog2(NOTES_PER_LEVEL);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);

    localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTES_PER_LEVEL - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_LEVELS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS);

    state_e              state_q,      state_d;
    logic [SEL_W-1:0]    sel_q,        sel_d;
    logic                play_en_q,    play_en_d;
    logic [NOTE_W-1:0]   note_idx_q,   note_idx_d;
    logic                level_done_q, level_done_d;
    logic                all_done_q,   all_done_d;
    logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
    logic                start_rise;
    logic [SEL_W-1:0]    sel_next;

    rise_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (start),
        .pulse (start_rise)
    );

    // Wrap keeps sel inside the level range even in the looping build.
    assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        play_en_d    = play_en_q;
        note_idx_d   = note_idx_q;
        level_done_d = 1'b0;
        all_done_d   = all_done_q;
        gap_cnt_d    = gap_cnt_q;

        case (state_q)
            IDLE, FINISH: begin
                if (start_rise) begin
                    state_d    = PLAY;
                    sel_d      = '0;
                    note_idx_d = '0;
                    play_en_d  = 1'b1;
                    all_done_d = 1'b0;
                end
            end

            PLAY: begin
                if (skip || (note_tick && note_idx_q == NOTE_LAST)) begin
                    level_done_d = 1'b1;
                    play_en_d    = 1'b0;
                    note_idx_d   = '0;
                    gap_cnt_d    = '0;
`ifdef LEVEL_SEQ_LOOP_EN
                    state_d      = GAP;
`else
                    if (sel_q == SEL_LAST) begin
                        state_d    = FINISH;
                        all_done_d = 1'b1;
                    end else begin
                        state_d    = GAP;
                    end
`endif
                end else if (note_tick) begin
                    note_idx_d = note_idx_q + NOTE_W'(1);
                end
            end

            GAP: begin
                play_en_d = 1'b0;
                if (note_tick) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (gap_cnt_d == GAP_LAST) begin
                        state_d    = PLAY;
                        sel_d      = sel_next;
                        note_idx_d = '0;
                        play_en_d  = 1'b1;
                        gap_cnt_d  = '0;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                sel_d      = '0;
                play_en_d  = 1'b0;
                note_idx_d = '0;
                all_done_d = 1'b0;
                gap_cnt_d  = '0;
            end
        endcase
    end

    // NOTE: every register, counters included, is cleared by rst so nothing from an interrupted game survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            play_en_q    <= 1'b0;
            note_idx_q   <= '0;
            level_done_q <= 1'b0;
            all_done_q   <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            play_en_q    <= play_en_d;
            note_idx_q   <= note_idx_d;
            level_done_q <= level_done_d;
            all_done_q   <= all_done_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign sel        = sel_q;
    assign play_en    = play_en_q;
    assign note_idx   = note_idx_q;
    assign level_done = level_done_q;
    assign all_done   = all_done_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed scenarios plus random stimulus against a game-level model.
module tb_level_sequencer;

    localparam int NUM_LEVELS = 4;
    localparam int NOTES      = 16;
    localparam int GAP_TICKS  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       skip;
    logic       note_tick;
    logic [1:0] sel;
    logic       play_en;
    logic [3:0] note_idx;
    logic       level_done;
    logic       all_done;

    int errors = 0;
    int checks = 0;

    // Game model: which level, which note, how far through the gap, and what the player sees.
    int m_level;
    int m_note;
    int m_gap_cnt;
    bit m_playing;
    bit m_in_gap;
    bit m_finished;
    bit m_done;
    bit m_prev_start;

    always #5 clk = ~clk;

    level_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .skip       (skip),
        .note_tick  (note_tick),
        .sel        (sel),
        .play_en    (play_en),
        .note_idx   (note_idx),
        .level_done (level_done),
        .all_done   (all_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level      = 0;
        m_note       = 0;
        m_gap_cnt    = 0;
        m_playing    = 1'b0;
        m_in_gap     = 1'b0;
        m_finished   = 1'b0;
        m_done       = 1'b0;
        m_prev_start = 1'b0;
    endtask

    task automatic finish_level();
        m_done    = 1'b1;
        m_playing = 1'b0;
        m_note    = 0;
`ifdef LEVEL_SEQ_LOOP_EN
        m_in_gap  = 1'b1;
        m_gap_cnt = 0;
`else
        if (m_level == NUM_LEVELS - 1) begin
            m_finished = 1'b1;
        end else begin
            m_in_gap  = 1'b1;
            m_gap_cnt = 0;
        end
`endif
    endtask

    task automatic model_step(input bit s, input bit k, input bit t);
        bit rise;
        rise         = s && !m_prev_start;
        m_prev_start = s;
        m_done       = 1'b0;
        if (m_playing) begin
            if (k || (t && m_note == NOTES - 1)) finish_level();
            else if (t) m_note++;
        end else if (m_in_gap) begin
            if (t) begin
                m_gap_cnt++;
                if (m_gap_cnt == GAP_TICKS) begin
                    m_in_gap  = 1'b0;
                    m_playing = 1'b1;
                    m_level   = (m_level + 1) % NUM_LEVELS;
                    m_note    = 0;
                end
            end
        end else if (rise) begin
            m_playing  = 1'b1;
            m_finished = 1'b0;
            m_level    = 0;
            m_note     = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sel"},        32'(sel),        32'(m_level));
        check({tag, ".play_en"},    32'(play_en),    32'(m_playing));
        check({tag, ".note_idx"},   32'(note_idx),   32'(m_note));
        check({tag, ".level_done"}, 32'(level_done), 32'(m_done));
        check({tag, ".all_done"},   32'(all_done),   32'(m_finished));
    endtask

    task automatic cycle(input bit s, input bit k, input bit t, input string tag);
        @(negedge clk);
        start     = s;
        skip      = k;
        note_tick = t;
        @(posedge clk);
        model_step(s, k, t);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b0;
        skip      = 1'b0;
        note_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit saw_last;
        bit rs;
        bit hit;

        rst       = 1'b1;
        start     = 1'b0;
        skip      = 1'b0;
        note_tick = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Held start: a single transition into level 0.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, "hold_start");
        check("hold_start.play_en", 32'(play_en), 32'd1);
        check("hold_start.sel",     32'(sel),     32'd0);
        cycle(1'b0, 1'b0, 1'b0, "release");
        cycle(1'b1, 1'b0, 1'b0, "rise_in_play");

        // First level plus its gap.
        for (int i = 0; i < NOTES + GAP_TICKS; i++) cycle(1'b0, 1'b0, 1'b1, "level0");
        check("after_gap.sel",     32'(sel),     32'd1);
        check("after_gap.play_en", 32'(play_en), 32'd1);

        // Remainder of the game.
        saw_last = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cycle(1'b0, 1'b0, 1'b1, "game");
            if (m_level == NUM_LEVELS - 1) saw_last = 1'b1;
`ifdef LEVEL_SEQ_LOOP_EN
            if (saw_last && m_level == 0 && m_playing) hit = 1'b1;
`else
            if (m_finished) hit = 1'b1;
`endif
        end
        check("game_end_reached", 32'(hit), 32'd1);
`ifdef LEVEL_SEQ_LOOP_EN
        check("loop.all_done", 32'(all_done), 32'd0);
        check("loop.sel",      32'(sel),      32'd0);
`else
        check("finish.all_done", 32'(all_done), 32'd1);
        check("finish.sel",      32'(sel),      32'd3);
`endif
        cycle(1'b0, 1'b0, 1'b1, "finish_idle");
        cycle(1'b1, 1'b0, 1'b0, "restart");
        check("restart.sel",      32'(sel),      32'd0);
        check("restart.all_done", 32'(all_done), 32'd0);

        // Skip coincident with a tick at note 5 of level 2.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, "skip_start");
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cycle(1'b0, 1'b0, 1'b1, "to_skip");
            if (m_playing && m_level == 2 && m_note == 5) hit = 1'b1;
        end
        check("skip_point_reached", 32'(hit), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, "skip");
        check("skip.level_done", 32'(level_done), 32'd1);
        check("skip.note_idx",   32'(note_idx),   32'd0);
        check("skip.play_en",    32'(play_en),    32'd0);
        for (int i = 0; i < GAP_TICKS - 1; i++) cycle(1'b0, 1'b0, 1'b1, "skip_gap");
        check("skip_gap.sel", 32'(sel), 32'd2);
        cycle(1'b0, 1'b0, 1'b1, "skip_gap_end");
        check("skip_gap_end.sel", 32'(sel), 32'd3);

        // Asynchronous reset in the middle of the level-1 gap.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, "ar_start");
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cycle(1'b0, 1'b0, 1'b1, "to_ar");
            if (m_in_gap && m_level == 1 && m_gap_cnt == 3) hit = 1'b1;
        end
        check("ar_point_reached", 32'(hit), 32'd1);
        start = 1'b0;
        note_tick = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, "ar_idle");
        cycle(1'b1, 1'b0, 1'b0, "ar_restart");
        check("ar_restart.sel", 32'(sel), 32'd0);

        // Random stimulus.
        do_reset();
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rs = ~rs;
            cycle(rs, ($urandom_range(49) == 0), 1'($urandom_range(1)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
